counter_sequencer: RTL and testbench

Run controller for the 4-bit up-counter.
- Drives the counter's synchronous clear and enable inputs and watches its count bits.
- Sequences a programmable number of 0→limit sweeps, with pause (hold) and abort (stop).
- Reports progress on `pass_cnt`, `busy` and a one-cycle `done` pulse.
- Sits between the control logic (or bench) and the counter; the counter itself has no run/stop logic.

---
 rtl/counter_sequencer_if.sv | 29 ++
 rtl/counter_sequencer.sv | 97 +++++++++
 tb/tb_counter_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// Control and counter-side signals of the counter run sequencer.
// start is a level request sampled only in IDLE; there is no ready/ack, busy tells the caller when it is taken.
interface counter_sequencer_if #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 4
);
    logic              start;
    logic              stop;
    logic              hold;
    logic [WIDTH-1:0]  limit;
    logic [PASS_W-1:0] passes;
    logic [WIDTH-1:0]  count_in;
    logic              cnt_clr;
    logic              cnt_en;
    logic              busy;
    logic              done;
    logic [PASS_W-1:0] pass_cnt;
    logic [1:0]        state;

    modport master (
        output start, stop, hold, limit, passes, count_in,
        input  cnt_clr, cnt_en, busy, done, pass_cnt, state
    );

    modport slave (
        input  start, stop, hold, limit, passes, count_in,
        output cnt_clr, cnt_en, busy, done, pass_cnt, state
    );
endinterface

// File: rtl/counter_sequencer.sv
// Run controller for an external up-counter: sequences a number of 0..limit
// sweeps with hold and stop, reporting pass count, busy and a done pulse.
module counter_sequencer #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 4
) (
    input logic               clock,
    input logic               reset,
    counter_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        RUN   = 2'b10,
        PAUSE = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [WIDTH-1:0]  limit_q, limit_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic              done_q, done_d;

    logic              terminal;
    logic [PASS_W-1:0] pass_next;

    assign terminal  = (bus.count_in == limit_q);
    assign pass_next = pass_cnt_q + PASS_W'(1);

    always_comb begin
        state_d    = state_q;
        pass_cnt_d = pass_cnt_q;
        limit_d    = limit_q;
        passes_d   = passes_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    limit_d    = bus.limit;
                    passes_d   = bus.passes;
                    pass_cnt_d = '0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                state_d = bus.stop ? IDLE : RUN;
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (terminal) begin
                    pass_cnt_d = pass_next;
                    // passes_q == 0 means run until stopped; pass_cnt simply wraps.
                    if ((passes_q != '0) && (pass_next == passes_q)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CLEAR;
                    end
                end else if (bus.hold) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (!bus.hold) begin
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pass_cnt_q <= '0;
            limit_q    <= '0;
            passes_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pass_cnt_q <= pass_cnt_d;
            limit_q    <= limit_d;
            passes_q   <= passes_d;
            done_q     <= done_d;
        end
    end

    // Enable is gated by the terminal compare so the counter stops exactly at limit.
    assign bus.cnt_en   = (state_q == RUN) && !bus.stop && !bus.hold && !terminal;
    assign bus.cnt_clr  = (state_q == CLEAR);
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.pass_cnt = pass_cnt_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural 4-bit counter on its
// clear/enable outputs.
module tb_counter_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    counter_sequencer_if #(.WIDTH(4), .PASS_W(4)) bus ();

    counter_sequencer #(.WIDTH(4), .PASS_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    logic [3:0] cnt = 4'd0;
    always_ff @(posedge clock) begin
        if (bus.cnt_clr) cnt <= 4'd0;
        else if (bus.cnt_en) cnt <= cnt + 4'd1;
    end
    assign bus.count_in = cnt;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    logic [15:0] clr_mask;
    logic [15:0] done_mask;
    logic        en_seen;
    int          done_seen;

    initial begin
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.hold   = 1'b0;
        bus.limit  = 4'd0;
        bus.passes = 4'd0;

        // Reset state
        #1;
        check("rst_state", bus.state, 2'b00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_pass", bus.pass_cnt, 4'd0);
        check("rst_clr", bus.cnt_clr, 1'b0);
        check("rst_en", bus.cnt_en, 1'b0);
        step();
        step();
        #2 reset = 1'b0;
        step();
        check("idle_state", bus.state, 2'b00);

        // limit=5, passes=2
        bus.limit  = 4'd5;
        bus.passes = 4'd2;
        bus.start  = 1'b1;
        step();                          // E0
        bus.start  = 1'b0;
        clr_mask = '0;
        done_mask = '0;
        clr_mask[0] = bus.cnt_clr;
        done_mask[0] = bus.done;
        check("t1_state_e0", bus.state, 2'b01);
        check("t1_busy_e0", bus.busy, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            step();
            clr_mask[i]  = bus.cnt_clr;
            done_mask[i] = bus.done;
            if (i == 1) begin
                check("t1_cnt_e1", bus.count_in, 4'd0);
                check("t1_en_e1", bus.cnt_en, 1'b1);
            end
            if (i == 6) begin
                check("t1_cnt_e6", bus.count_in, 4'd5);
                check("t1_en_e6", bus.cnt_en, 1'b0);
            end
            if (i == 7) check("t1_pass_e7", bus.pass_cnt, 4'd1);
            if (i == 13) check("t1_cnt_e13", bus.count_in, 4'd5);
            if (i == 14) begin
                check("t1_pass_e14", bus.pass_cnt, 4'd2);
                check("t1_busy_e14", bus.busy, 1'b0);
                check("t1_state_e14", bus.state, 2'b00);
            end
        end
        check("t1_clr_mask", clr_mask, 16'h0081);
        check("t1_done_mask", done_mask, 16'h4000);
        check("t1_pass_hold", bus.pass_cnt, 4'd2);

        // limit=3, passes=1, hold for 4 edges starting at count 1
        bus.limit  = 4'd3;
        bus.passes = 4'd1;
        bus.start  = 1'b1;
        step();                          // E0
        bus.start  = 1'b0;
        step();                          // E1
        step();                          // E2
        check("t2_cnt_e2", bus.count_in, 4'd1);
        bus.hold = 1'b1;
        #1;
        check("t2_en_hold", bus.cnt_en, 1'b0);
        step();                          // E3
        check("t2_state_e3", bus.state, 2'b11);
        check("t2_cnt_e3", bus.count_in, 4'd1);
        step();
        step();
        step();                          // E6
        check("t2_state_e6", bus.state, 2'b11);
        check("t2_cnt_e6", bus.count_in, 4'd1);
        bus.hold = 1'b0;
        step();                          // E7
        check("t2_state_e7", bus.state, 2'b10);
        step();
        step();                          // E9
        check("t2_cnt_e9", bus.count_in, 4'd3);
        check("t2_done_e9", bus.done, 1'b0);
        step();                          // E10
        check("t2_done_e10", bus.done, 1'b1);
        check("t2_pass_e10", bus.pass_cnt, 4'd1);
        check("t2_state_e10", bus.state, 2'b00);
        step();
        check("t2_done_e11", bus.done, 1'b0);

        // stop in RUN at count 2 during the second sweep
        bus.limit  = 4'd3;
        bus.passes = 4'd3;
        bus.start  = 1'b1;
        step();                          // E0
        bus.start  = 1'b0;
        repeat (8) step();               // E8
        check("t3_cnt_e8", bus.count_in, 4'd2);
        check("t3_pass_e8", bus.pass_cnt, 4'd1);
        bus.stop = 1'b1;
        #1;
        check("t3_en_stop", bus.cnt_en, 1'b0);
        step();                          // E9
        check("t3_state_e9", bus.state, 2'b00);
        check("t3_done_e9", bus.done, 1'b0);
        check("t3_pass_e9", bus.pass_cnt, 4'd1);
        check("t3_cnt_e9", bus.count_in, 4'd2);
        bus.stop = 1'b0;
        step();
        check("t3_done_after", bus.done, 1'b0);
        check("t3_pass_after", bus.pass_cnt, 4'd1);

        // stop in PAUSE
        bus.limit  = 4'd3;
        bus.passes = 4'd2;
        bus.start  = 1'b1;
        step();                          // E0
        bus.start  = 1'b0;
        step();                          // E1
        bus.hold = 1'b1;
        step();                          // E2
        check("t4_state_pause", bus.state, 2'b11);
        bus.stop = 1'b1;
        step();                          // E3
        check("t4_state_stop", bus.state, 2'b00);
        check("t4_done_stop", bus.done, 1'b0);
        check("t4_pass_stop", bus.pass_cnt, 4'd0);
        bus.stop = 1'b0;
        bus.hold = 1'b0;
        step();
        check("t4_state_after", bus.state, 2'b00);
        check("t4_done_after", bus.done, 1'b0);

        // limit=0, passes=3, second start at E2 is ignored
        bus.limit  = 4'd0;
        bus.passes = 4'd3;
        bus.start  = 1'b1;
        step();                          // E0
        bus.start = 1'b0;
        en_seen = bus.cnt_en;
        done_mask = '0;
        done_mask[0] = bus.done;
        for (int i = 1; i <= 7; i++) begin
            step();
            bus.start = (i == 1);
            en_seen = en_seen | bus.cnt_en;
            done_mask[i] = bus.done;
            if (i == 6) check("t5_pass_e6", bus.pass_cnt, 4'd3);
        end
        bus.start = 1'b0;
        check("t5_done_mask", done_mask, 16'h0040);
        check("t5_en_never", en_seen, 1'b0);
        check("t5_state_end", bus.state, 2'b00);

        // continuous mode, limit=2: pass_cnt wraps at E64
        bus.limit  = 4'd2;
        bus.passes = 4'd0;
        bus.start  = 1'b1;
        step();                          // E0
        bus.start = 1'b0;
        done_seen = 0;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (bus.done) done_seen++;
            if (i == 4) check("t6_pass_e4", bus.pass_cnt, 4'd1);
            if (i == 60) check("t6_pass_e60", bus.pass_cnt, 4'd15);
            if (i == 64) begin
                check("t6_pass_e64", bus.pass_cnt, 4'd0);
                check("t6_state_e64", bus.state, 2'b01);
            end
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        if (bus.done) done_seen++;
        check("t6_state_stop", bus.state, 2'b00);
        step();
        if (bus.done) done_seen++;
        check("t6_done_count", done_seen, 0);

        // asynchronous reset mid-run with count 3
        bus.limit  = 4'd3;
        bus.passes = 4'd2;
        bus.start  = 1'b1;
        step();                          // E0
        bus.start = 1'b0;
        repeat (9) step();               // E9
        check("t7_cnt_e9", bus.count_in, 4'd3);
        check("t7_pass_e9", bus.pass_cnt, 4'd1);
        check("t7_state_e9", bus.state, 2'b10);
        #2 reset = 1'b1;
        #1;
        check("t7_rst_state", bus.state, 2'b00);
        check("t7_rst_busy", bus.busy, 1'b0);
        check("t7_rst_en", bus.cnt_en, 1'b0);
        check("t7_rst_clr", bus.cnt_clr, 1'b0);
        check("t7_rst_pass", bus.pass_cnt, 4'd0);
        check("t7_rst_done", bus.done, 1'b0);
        step();
        #2 reset = 1'b0;
        step();
        check("t7_post_state", bus.state, 2'b00);
        check("t7_post_done", bus.done, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
